// File: rtl/tl_buf_pkg.sv
// Shared definitions for the parametrised TileLink-C channel buffer:
// per-channel payload widths, channel index enum and occupancy width helper.
package tl_buf_pkg;

  localparam int TL_OPCODE_W  = 3;
  localparam int TL_PARAM_AC_W = 3;
  localparam int TL_PARAM_BD_W = 2;
  localparam int TL_SIZE_W    = 4;
  localparam int TL_SOURCE_W  = 4;
  localparam int TL_ADDR_W    = 32;
  localparam int TL_MASK_W    = 8;
  localparam int TL_DATA_W    = 64;
  localparam int TL_SINK_W    = 3;
  localparam int TL_FLAG_W    = 1;  // corrupt / denied

  // A: opcode, param, size, source, address, mask, data, corrupt
  localparam int A_W = TL_OPCODE_W + TL_PARAM_AC_W + TL_SIZE_W + TL_SOURCE_W +
                       TL_ADDR_W + TL_MASK_W + TL_DATA_W + TL_FLAG_W;
  // B: opcode, param, size, source, address, mask, data, corrupt
  localparam int B_W = TL_OPCODE_W + TL_PARAM_BD_W + TL_SIZE_W + TL_SOURCE_W +
                       TL_ADDR_W + TL_MASK_W + TL_DATA_W + TL_FLAG_W;
  // C: opcode, param, size, source, address, data, corrupt
  localparam int C_W = TL_OPCODE_W + TL_PARAM_AC_W + TL_SIZE_W + TL_SOURCE_W +
                       TL_ADDR_W + TL_DATA_W + TL_FLAG_W;
  // D: opcode, param, size, source, sink, denied, data, corrupt
  localparam int D_W = TL_OPCODE_W + TL_PARAM_BD_W + TL_SIZE_W + TL_SOURCE_W +
                       TL_SINK_W + TL_FLAG_W + TL_DATA_W + TL_FLAG_W;
  // E: sink
  localparam int E_W = TL_SINK_W;

  localparam int NUM_CH = 5;

  typedef enum logic [2:0] {
    CH_A = 3'd0,
    CH_B = 3'd1,
    CH_C = 3'd2,
    CH_D = 3'd3,
    CH_E = 3'd4
  } tl_chan_e;

  // Width of an occupancy counter able to hold 0..depth (1 bit for wire-through).
  function automatic int occ_w(input int depth);
    if (depth <= 0) begin
      return 1;
    end else begin
      return $clog2(depth + 1);
    end
  endfunction

endpackage

// File: rtl/tl_buffer_param_queue.sv
// Single-channel circular queue used by tl_buffer_param.
// DEPTH=0 is a pure wire; FLOW lets an empty queue forward in the same
// cycle; PIPE lets a full queue accept while it is being drained.
module tl_chan_queue
  import tl_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0,
  localparam int CW   = occ_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [WIDTH-1:0] i_enq_bits,
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [WIDTH-1:0] o_deq_bits,
  output logic [CW-1:0]    o_count
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused    = ^{clock, reset, FLOW, PIPE};
    assign o_deq_valid = i_enq_valid;
    assign o_deq_bits  = i_enq_bits;
    assign o_enq_ready = i_deq_ready;
    assign o_count     = '0;
  end else begin : g_buf
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_flow;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_write;
    logic w_read;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // An empty flow queue passes the enq beat straight through.
    assign w_flow  = FLOW && w_empty;

    // Valid is qualified by reset so queued beats vanish as soon as reset asserts.
    assign o_deq_valid = reset && (!w_empty || (FLOW && i_enq_valid));
    assign o_deq_bits  = w_flow ? i_enq_bits : r_mem[r_rptr];
    assign o_enq_ready = !w_full || (PIPE && i_deq_ready);
    assign o_count     = r_count;

    assign w_enq_fire = i_enq_valid && o_enq_ready;
    assign w_deq_fire = o_deq_valid && i_deq_ready;
    // A beat that flows through in the same cycle never touches storage.
    assign w_write    = w_enq_fire && !(w_flow && w_deq_fire);
    assign w_read     = w_deq_fire && !w_empty;

    // Pointer and occupancy state; pointers wrap at DEPTH-1 for any depth.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_write) begin
          r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        end
        if (w_read) begin
          r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        end
        case ({w_write, w_read})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Payload storage; contents are intentionally left unreset.
    always_ff @(posedge clock) begin
      if (w_write) begin
        r_mem[r_wptr] <= i_enq_bits;
      end
    end
  end

endmodule

// File: rtl/tl_buffer_param.sv
// Parametrised TileLink-C buffer: one tl_chan_queue per channel between the
// client ("in") and manager ("out") ports, plus occupancy and idle status.
// Optional: define TL_BUFFER_STALL_CHECK_EN to add the enq-side stability
// checker and its sticky proto_err output.
module tl_buffer_param
  import tl_buf_pkg::*;
#(
  parameter int       DEPTH_A   = 2,
  parameter int       DEPTH_B   = 2,
  parameter int       DEPTH_C   = 2,
  parameter int       DEPTH_D   = 2,
  parameter int       DEPTH_E   = 2,
  parameter bit [4:0] FLOW_MASK = 5'b00000,
  parameter bit [4:0] PIPE_MASK = 5'b00000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_a_valid,
  output logic                        in_a_ready,
  input  logic [A_W-1:0]              in_a_bits,
  output logic                        out_a_valid,
  input  logic                        out_a_ready,
  output logic [A_W-1:0]              out_a_bits,
  input  logic                        out_b_valid,
  output logic                        out_b_ready,
  input  logic [B_W-1:0]              out_b_bits,
  output logic                        in_b_valid,
  input  logic                        in_b_ready,
  output logic [B_W-1:0]              in_b_bits,
  input  logic                        in_c_valid,
  output logic                        in_c_ready,
  input  logic [C_W-1:0]              in_c_bits,
  output logic                        out_c_valid,
  input  logic                        out_c_ready,
  output logic [C_W-1:0]              out_c_bits,
  input  logic                        out_d_valid,
  output logic                        out_d_ready,
  input  logic [D_W-1:0]              out_d_bits,
  output logic                        in_d_valid,
  input  logic                        in_d_ready,
  output logic [D_W-1:0]              in_d_bits,
  input  logic                        in_e_valid,
  output logic                        in_e_ready,
  input  logic [E_W-1:0]              in_e_bits,
  output logic                        out_e_valid,
  input  logic                        out_e_ready,
  output logic [E_W-1:0]              out_e_bits,
  output logic [occ_w(DEPTH_A)-1:0]   occ_a,
  output logic [occ_w(DEPTH_B)-1:0]   occ_b,
  output logic [occ_w(DEPTH_C)-1:0]   occ_c,
  output logic [occ_w(DEPTH_D)-1:0]   occ_d,
  output logic [occ_w(DEPTH_E)-1:0]   occ_e,
`ifdef TL_BUFFER_STALL_CHECK_EN
  output logic                        proto_err,
`endif
  output logic                        idle
);

  tl_chan_queue #(.WIDTH(A_W), .DEPTH(DEPTH_A), .FLOW(FLOW_MASK[CH_A]), .PIPE(PIPE_MASK[CH_A])) u_q_a (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_a_valid), .o_enq_ready(in_a_ready), .i_enq_bits(in_a_bits),
    .o_deq_valid(out_a_valid), .i_deq_ready(out_a_ready), .o_deq_bits(out_a_bits),
    .o_count(occ_a)
  );

  tl_chan_queue #(.WIDTH(B_W), .DEPTH(DEPTH_B), .FLOW(FLOW_MASK[CH_B]), .PIPE(PIPE_MASK[CH_B])) u_q_b (
    .clock(clock), .reset(reset),
    .i_enq_valid(out_b_valid), .o_enq_ready(out_b_ready), .i_enq_bits(out_b_bits),
    .o_deq_valid(in_b_valid), .i_deq_ready(in_b_ready), .o_deq_bits(in_b_bits),
    .o_count(occ_b)
  );

  tl_chan_queue #(.WIDTH(C_W), .DEPTH(DEPTH_C), .FLOW(FLOW_MASK[CH_C]), .PIPE(PIPE_MASK[CH_C])) u_q_c (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_c_valid), .o_enq_ready(in_c_ready), .i_enq_bits(in_c_bits),
    .o_deq_valid(out_c_valid), .i_deq_ready(out_c_ready), .o_deq_bits(out_c_bits),
    .o_count(occ_c)
  );

  tl_chan_queue #(.WIDTH(D_W), .DEPTH(DEPTH_D), .FLOW(FLOW_MASK[CH_D]), .PIPE(PIPE_MASK[CH_D])) u_q_d (
    .clock(clock), .reset(reset),
    .i_enq_valid(out_d_valid), .o_enq_ready(out_d_ready), .i_enq_bits(out_d_bits),
    .o_deq_valid(in_d_valid), .i_deq_ready(in_d_ready), .o_deq_bits(in_d_bits),
    .o_count(occ_d)
  );

  tl_chan_queue #(.WIDTH(E_W), .DEPTH(DEPTH_E), .FLOW(FLOW_MASK[CH_E]), .PIPE(PIPE_MASK[CH_E])) u_q_e (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_e_valid), .o_enq_ready(in_e_ready), .i_enq_bits(in_e_bits),
    .o_deq_valid(out_e_valid), .i_deq_ready(out_e_ready), .o_deq_bits(out_e_bits),
    .o_count(occ_e)
  );

  // Wire-through channels report zero occupancy, so they count as empty here.
  assign idle = (occ_a == '0) && (occ_b == '0) && (occ_c == '0) &&
                (occ_d == '0) && (occ_e == '0);

`ifdef TL_BUFFER_STALL_CHECK_EN
  logic [NUM_CH-1:0] w_stall;
  logic [NUM_CH-1:0] w_viol;
  logic [NUM_CH-1:0] r_stall;
  logic              r_proto_err;
  logic [A_W-1:0]    r_prev_a;
  logic [B_W-1:0]    r_prev_b;
  logic [C_W-1:0]    r_prev_c;
  logic [D_W-1:0]    r_prev_d;
  logic [E_W-1:0]    r_prev_e;

  assign w_stall[CH_A] = in_a_valid  && !in_a_ready;
  assign w_stall[CH_B] = out_b_valid && !out_b_ready;
  assign w_stall[CH_C] = in_c_valid  && !in_c_ready;
  assign w_stall[CH_D] = out_d_valid && !out_d_ready;
  assign w_stall[CH_E] = in_e_valid  && !in_e_ready;

  // A beat stalled last cycle must still be offered, with identical bits.
  assign w_viol[CH_A] = r_stall[CH_A] && (!in_a_valid  || (in_a_bits  != r_prev_a));
  assign w_viol[CH_B] = r_stall[CH_B] && (!out_b_valid || (out_b_bits != r_prev_b));
  assign w_viol[CH_C] = r_stall[CH_C] && (!in_c_valid  || (in_c_bits  != r_prev_c));
  assign w_viol[CH_D] = r_stall[CH_D] && (!out_d_valid || (out_d_bits != r_prev_d));
  assign w_viol[CH_E] = r_stall[CH_E] && (!in_e_valid  || (in_e_bits  != r_prev_e));

  // Track stall state per channel and latch any violation until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_stall <= w_stall;
      if (|w_viol) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Snapshot of the offered enq bits for next-cycle comparison.
  always_ff @(posedge clock) begin
    r_prev_a <= in_a_bits;
    r_prev_b <= out_b_bits;
    r_prev_c <= in_c_bits;
    r_prev_d <= out_d_bits;
    r_prev_e <= in_e_bits;
  end

  assign proto_err = r_proto_err;

`ifndef SYNTHESIS
  // Flag a stability violation in simulation as soon as it is observed.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (w_viol == '0);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_tl_buffer_param.sv
// Directed, self-checking bench for tl_buffer_param with scoreboards on A and D.
module tb_tl_buffer_param;
  import tl_buf_pkg::*;

  localparam int TB_DEPTH_A = 3;
  localparam int TB_DEPTH_B = 0;
  localparam int TB_DEPTH_C = 2;
  localparam int TB_DEPTH_D = 2;
  localparam int TB_DEPTH_E = 2;

  logic clock = 1'b0;
  logic reset;
  logic in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [A_W-1:0] in_a_bits, out_a_bits;
  logic out_b_valid, out_b_ready, in_b_valid, in_b_ready;
  logic [B_W-1:0] out_b_bits, in_b_bits;
  logic in_c_valid, in_c_ready, out_c_valid, out_c_ready;
  logic [C_W-1:0] in_c_bits, out_c_bits;
  logic out_d_valid, out_d_ready, in_d_valid, in_d_ready;
  logic [D_W-1:0] out_d_bits, in_d_bits;
  logic in_e_valid, in_e_ready, out_e_valid, out_e_ready;
  logic [E_W-1:0] in_e_bits, out_e_bits;
  logic [occ_w(TB_DEPTH_A)-1:0] occ_a;
  logic [occ_w(TB_DEPTH_B)-1:0] occ_b;
  logic [occ_w(TB_DEPTH_C)-1:0] occ_c;
  logic [occ_w(TB_DEPTH_D)-1:0] occ_d;
  logic [occ_w(TB_DEPTH_E)-1:0] occ_e;
  logic idle;
`ifdef TL_BUFFER_STALL_CHECK_EN
  logic proto_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [A_W-1:0] qa[$];
  logic [D_W-1:0] qd[$];
  int cnt_a = 0;
  int cnt_d = 0;
  logic [A_W-1:0] a_beats [10];
  logic [D_W-1:0] d_beats [3];
  logic [C_W-1:0] c_beats [3];

  tl_buffer_param #(
    .DEPTH_A(TB_DEPTH_A), .DEPTH_B(TB_DEPTH_B), .DEPTH_C(TB_DEPTH_C),
    .DEPTH_D(TB_DEPTH_D), .DEPTH_E(TB_DEPTH_E),
    .FLOW_MASK(5'b10000), .PIPE_MASK(5'b00100)
  ) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_bits(out_b_bits),
    .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_bits(in_b_bits),
    .in_c_valid(in_c_valid), .in_c_ready(in_c_ready), .in_c_bits(in_c_bits),
    .out_c_valid(out_c_valid), .out_c_ready(out_c_ready), .out_c_bits(out_c_bits),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_bits(in_d_bits),
    .in_e_valid(in_e_valid), .in_e_ready(in_e_ready), .in_e_bits(in_e_bits),
    .out_e_valid(out_e_valid), .out_e_ready(out_e_ready), .out_e_bits(out_e_bits),
    .occ_a(occ_a), .occ_b(occ_b), .occ_c(occ_c), .occ_d(occ_d), .occ_e(occ_e),
`ifdef TL_BUFFER_STALL_CHECK_EN
    .proto_err(proto_err),
`endif
    .idle(idle)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A-channel model step, called at the falling edge; returns whether enq fires.
  task automatic a_check(output bit enq);
    bit deq;
    logic [A_W-1:0] e;
    chk("a_occ", occ_a, cnt_a);
    chk("a_ready", in_a_ready, cnt_a < TB_DEPTH_A);
    chk("a_valid", out_a_valid, cnt_a > 0);
    enq = in_a_valid && (cnt_a < TB_DEPTH_A);
    deq = (cnt_a > 0) && out_a_ready;
    if (deq) begin
      e = qa.pop_front();
      chk("a_data", out_a_bits, e);
    end
    if (enq) qa.push_back(in_a_bits);
    cnt_a = cnt_a + int'(enq) - int'(deq);
  endtask

  // D-channel model step (enq on out_d_*, deq on in_d_*).
  task automatic d_check(output bit enq);
    bit deq;
    logic [D_W-1:0] e;
    chk("d_occ", occ_d, cnt_d);
    chk("d_ready", out_d_ready, cnt_d < TB_DEPTH_D);
    chk("d_valid", in_d_valid, cnt_d > 0);
    enq = out_d_valid && (cnt_d < TB_DEPTH_D);
    deq = (cnt_d > 0) && in_d_ready;
    if (deq) begin
      e = qd.pop_front();
      chk("d_data", in_d_bits, e);
    end
    if (enq) qd.push_back(out_d_bits);
    cnt_d = cnt_d + int'(enq) - int'(deq);
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit enq;
    int sent;
    int cyc;
    int max_occ;

    for (int i = 0; i < 10; i++) a_beats[i] = A_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 3; i++)  d_beats[i] = D_W'({$urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 3; i++)  c_beats[i] = C_W'({$urandom(), $urandom(), $urandom(), $urandom()});

    reset = 1'b0;
    in_a_valid = 1'b1; in_a_bits = a_beats[0]; out_a_ready = 1'b0;
    out_b_valid = 1'b0; out_b_bits = '0; in_b_ready = 1'b0;
    in_c_valid = 1'b0; in_c_bits = '0; out_c_ready = 1'b0;
    out_d_valid = 1'b0; out_d_bits = '0; in_d_ready = 1'b0;
    in_e_valid = 1'b0; in_e_bits = '0; out_e_ready = 1'b0;

    // Reset held low for three cycles with A valid asserted.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_a_valid", out_a_valid, 1'b0);
    chk("rst_in_a_ready", in_a_ready, 1'b1);
    chk("rst_occ_a", occ_a, 0);
    chk("rst_idle", idle, 1'b1);

    // Release: first beat accepted, visible one cycle later.
    drive_edge();
    reset = 1'b1;
    @(negedge clock);
    a_check(enq);
    drive_edge();
    in_a_valid = 1'b0; out_a_ready = 1'b1;
    @(negedge clock);
    chk("idle_busy", idle, 1'b0);
    a_check(enq);
    drive_edge();
    out_a_ready = 1'b0;
    @(negedge clock);
    chk("idle_after_a", idle, 1'b1);
    a_check(enq);

    // Ten back-to-back A beats with random deq stalls across pointer wrap.
    sent = 0; cyc = 0; max_occ = 0;
    while ((sent < 10 || cnt_a > 0) && cyc < 300) begin
      drive_edge();
      in_a_valid  = (sent < 10);
      in_a_bits   = a_beats[(sent < 10) ? sent : 9];
      out_a_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (int'(occ_a) > max_occ) max_occ = int'(occ_a);
      a_check(enq);
      if (enq) sent++;
      cyc++;
    end
    chk("a_all_sent", sent, 10);
    chk("a_drained", cnt_a, 0);
    chk("a_max_occ_le3", max_occ <= TB_DEPTH_A, 1'b1);
    drive_edge();
    in_a_valid = 1'b0; out_a_ready = 1'b0;

    // D: fill to depth with consumer stalled, then drain one beat per cycle.
    sent = 0;
    for (int i = 0; i < 3; i++) begin
      out_d_valid = 1'b1;
      out_d_bits  = d_beats[sent];
      in_d_ready  = 1'b0;
      @(negedge clock);
      d_check(enq);
      if (enq) sent++;
      drive_edge();
    end
    chk("d_full_occ", occ_d, 2);
    chk("d_full_ready", out_d_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      out_d_valid = (sent < 3);
      out_d_bits  = d_beats[(sent < 3) ? sent : 2];
      in_d_ready  = 1'b1;
      @(negedge clock);
      chk("d_beat_per_cycle", in_d_valid, 1'b1);
      d_check(enq);
      if (enq) sent++;
      drive_edge();
    end
    out_d_valid = 1'b0; in_d_ready = 1'b0;
    @(negedge clock);
    chk("d_empty", occ_d, 0);
    chk("d_qempty", qd.size(), 0);

    // E flow: empty queue forwards in the same cycle without storing.
    drive_edge();
    in_e_valid = 1'b1; in_e_bits = 3'd5; out_e_ready = 1'b1;
    @(negedge clock);
    chk("e_flow_valid", out_e_valid, 1'b1);
    chk("e_flow_bits", out_e_bits, 3'd5);
    chk("e_flow_occ", occ_e, 0);
    drive_edge();
    in_e_valid = 1'b0;
    @(negedge clock);
    chk("e_flow_occ_after", occ_e, 0);
    chk("e_flow_valid_after", out_e_valid, 1'b0);
    drive_edge();
    in_e_valid = 1'b1; in_e_bits = 3'd6; out_e_ready = 1'b0;
    @(negedge clock);
    chk("e_flow_stall_bits", out_e_bits, 3'd6);
    drive_edge();
    in_e_valid = 1'b0; out_e_ready = 1'b1;
    @(negedge clock);
    chk("e_stored_occ", occ_e, 1);
    chk("e_stored_bits", out_e_bits, 3'd6);
    drive_edge();
    out_e_ready = 1'b0;
    @(negedge clock);
    chk("e_drained", occ_e, 0);

    // C pipe: full queue accepts while being drained.
    drive_edge();
    in_c_valid = 1'b1; in_c_bits = c_beats[0]; out_c_ready = 1'b0;
    @(negedge clock);
    chk("c_ready0", in_c_ready, 1'b1);
    drive_edge();
    in_c_bits = c_beats[1];
    @(negedge clock);
    chk("c_occ1", occ_c, 1);
    drive_edge();
    in_c_bits = c_beats[2]; out_c_ready = 1'b1;
    @(negedge clock);
    chk("c_full_occ", occ_c, 2);
    chk("c_pipe_ready", in_c_ready, 1'b1);
    chk("c_head", out_c_bits, c_beats[0]);
    drive_edge();
    in_c_valid = 1'b0;
    @(negedge clock);
    chk("c_pipe_occ_kept", occ_c, 2);
    chk("c_second", out_c_bits, c_beats[1]);
    drive_edge();
    @(negedge clock);
    chk("c_third", out_c_bits, c_beats[2]);
    chk("c_occ_third", occ_c, 1);
    drive_edge();
    out_c_ready = 1'b0;
    @(negedge clock);
    chk("c_drained", occ_c, 0);

    // B with depth 0: combinational wire in both directions.
    drive_edge();
    out_b_valid = 1'b1; out_b_bits = B_W'({$urandom(), $urandom(), $urandom(), $urandom()}); in_b_ready = 1'b0;
    #1;
    chk("b_wire_valid", in_b_valid, 1'b1);
    chk("b_wire_bits", in_b_bits, out_b_bits);
    chk("b_wire_ready0", out_b_ready, 1'b0);
    chk("b_occ", occ_b, 0);
    in_b_ready = 1'b1;
    #1;
    chk("b_wire_ready1", out_b_ready, 1'b1);
    out_b_valid = 1'b0; in_b_ready = 1'b0;

    // Reset mid-transfer discards queued A beats immediately.
    for (int i = 0; i < 2; i++) begin
      drive_edge();
      in_a_valid = 1'b1; in_a_bits = a_beats[i]; out_a_ready = 1'b0;
      @(negedge clock);
      a_check(enq);
    end
    drive_edge();
    in_a_valid = 1'b0;
    chk("pre_rst_occ_a", occ_a, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_a_valid, 1'b0);
    chk("mid_rst_occ", occ_a, 0);
    chk("mid_rst_ready", in_a_ready, 1'b1);
    chk("mid_rst_idle", idle, 1'b1);
    qa.delete();
    cnt_a = 0;
    drive_edge();
    reset = 1'b1;
    @(negedge clock);
    a_check(enq);
    chk("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_buffer_param.md
Name: tl_buffer_param

Overview:
- Parametrised TileLink-C channel buffer: one independent queue per channel (A, C, E master-to-slave; B, D slave-to-master) inserted between a client port ("in") and a manager port ("out").
- Successor to the fixed 2-entry TL buffer: per-channel depth, flow and pipe modes, depth-0 bypass, and per-channel occupancy and idle status.
- Sits on crossbar/tile boundaries wherever timing cuts or decoupling are needed.

Parameters:
- DEPTH_A, 2, entries on A; 0 = combinational wire-through
- DEPTH_B, 2, entries on B; 0 = wire-through
- DEPTH_C, 2, entries on C; 0 = wire-through
- DEPTH_D, 2, entries on D; 0 = wire-through
- DEPTH_E, 2, entries on E; 0 = wire-through
- FLOW_MASK, 5'b00000, bit i (A=0..E=4) set: empty queue forwards enq to deq in the same cycle
- PIPE_MASK, 5'b00000, bit i set: full queue accepts enq in the same cycle it is dequeued

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- in_a_valid/in_a_bits  in  1/A_W  client A request; in_a_ready  out  1
- out_a_valid/out_a_bits  out  1/A_W  manager A; out_a_ready  in  1
- out_b_valid/out_b_bits  in  1/B_W  manager B probe; out_b_ready  out  1
- in_b_valid/in_b_bits  out  1/B_W  client B; in_b_ready  in  1
- in_c_valid/in_c_bits  in  1/C_W  client C release; in_c_ready  out  1
- out_c_valid/out_c_bits  out  1/C_W  manager C; out_c_ready  in  1
- out_d_valid/out_d_bits  in  1/D_W  manager D grant/response; out_d_ready  out  1
- in_d_valid/in_d_bits  out  1/D_W  client D; in_d_ready  in  1
- in_e_valid/in_e_bits  in  1/E_W  client E grant-ack; in_e_ready  out  1
- out_e_valid/out_e_bits  out  1/E_W  manager E; out_e_ready  in  1
- occ_a..occ_e  out  $clog2(DEPTH_x+1) each (1 if DEPTH_x=0, tied 0)  current entry count
- idle  out  1  all five queues empty

Behaviour:
- Each channel is a circular buffer: write pointer, read pointer, count. Pointers wrap from DEPTH-1 to 0 (non-power-of-2 depths legal).
- Reset (reset low, asynchronous assert, synchronous-to-clock deassert by upstream): pointers and counts 0; all deq valids 0; all enq readies 1; idle 1. Storage contents not reset.
- enq fires on valid&&ready; deq fires on valid&&ready; bits held stable while deq valid and not ready.
- Default (no flow, no pipe): enq_ready = count<DEPTH; deq_valid = count>0; latency enq->deq 1 cycle; full throughput 1 beat/cycle at DEPTH>=2; DEPTH=1 gives 1 beat every 2 cycles.
- FLOW bit set: when count==0, deq_valid = enq_valid, deq_bits = enq_bits (0 cycles); if deq fires same cycle, entry not written and count stays 0.
- PIPE bit set: when count==DEPTH, enq_ready = deq_ready; simultaneous enq/deq keeps count at DEPTH.
- Simultaneous enq and deq at 0<count<DEPTH: both pointers advance, count unchanged.
- DEPTH_x=0: pure wires both directions, FLOW/PIPE ignored, occ_x=0.
- No payload field modification; corrupt/denied travel inside bits.
- reset asserted mid-transfer: queued beats discarded immediately; valids drop asynchronously.
- idle = AND of (count==0) across buffered channels (depth-0 channels count as empty).

Optional Feature:
- TL_BUFFER_STALL_CHECK_EN: when defined, adds per-channel stability checker on enq side: while in valid && !ready, bits must not change and valid must not drop; violation sets sticky output proto_err (1 bit, cleared only by reset) and fires an immediate assertion outside SYNTHESIS. Without macro: no proto_err port, no checker logic.

Decomposition:
- Package tl_buf_pkg: A_W, B_W, C_W, D_W, E_W localparams from TL field widths (opcode 3, param 3/2, size 4, source 4, address 32, mask 8, data 64, sink 3, flags); channel index enum CH_A..CH_E; occupancy width function.
- Sub-module tl_chan_queue (params WIDTH, DEPTH, FLOW, PIPE): one per channel, instantiated five times; top does wiring, idle and optional checker only.

Test Plan:
- Reset low for 3 cycles with in_a_valid=1 -> out_a_valid=0, in_a_ready=1, occ_a=0, idle=1; on release first beat appears on out_a one cycle after acceptance.
- DEPTH_D=2, out_d_valid held 1, in_d_ready=0 -> 2 beats accepted, occ_d=2, out_d_ready=0; raise in_d_ready -> beats emerge in order, 1/cycle.
- DEPTH_A=3, 10 back-to-back beats with random deq stalls -> order and data preserved across pointer wrap, occ_a never exceeds 3.
- FLOW_MASK[E]=1, empty E, in_e_valid=1 sink=5, out_e_ready=1 -> out_e_valid=1 sink=5 same cycle, occ_e stays 0.
- PIPE_MASK[C]=1, C full, out_c_ready=1, in_c_valid=1 -> in_c_ready=1, occ_c stays DEPTH_C; PIPE clear -> in_c_ready=0.
- With TL_BUFFER_STALL_CHECK_EN, change in_a_bits address while stalled -> proto_err=1 next cycle, remains 1 until reset.
